// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals between uart_rx and its consumer
interface uart_rx_if;
  logic       input_rx;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  modport master (
    input  input_rx,
    output data_byte, data_valid, framing_error, parity_error, busy
  );

  modport slave (
    output input_rx,
    input  data_byte, data_valid, framing_error, parity_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and break handling
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx #(
  parameter int baudrate     = 115200,
  parameter int clk_freq     = 10000000,
  parameter int clks_per_bit = clk_freq / baudrate,
  parameter int half_bit     = clks_per_bit / 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam logic [15:0] CPB_M1  = 16'(clks_per_bit - 1);
  localparam logic [15:0] HALF_M1 = 16'(half_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic        sync1_q, rx_sync_q;
  logic        stop_ok_q, stop_ok_d;
  logic        stop_bad_q, stop_bad_d;
  logic [7:0]  data_byte_q;
  logic        data_valid_q;
  logic        framing_error_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        parity_error_q;
`endif

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q + 16'd1;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    stop_ok_d   = 1'b0;
    stop_bad_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_count_d = 16'd0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (clk_count_q == HALF_M1) state_d = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (clk_count_q == CPB_M1) begin
          shift_d[bit_index_q] = rx_sync_q;
          bit_index_d          = bit_index_q + 3'd1;
          clk_count_d          = 16'd0;
`ifdef UART_RX_PARITY_EN
          if (bit_index_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_index_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_count_q == CPB_M1) begin
          par_bad_d = ^shift_q ^ rx_sync_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_count_q == CPB_M1) begin
          stop_ok_d  = rx_sync_q;
          stop_bad_d = !rx_sync_q;
          state_d    = rx_sync_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it is never decoded as further frames.
        clk_count_d = 16'd0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      clk_count_d = 16'd0;
      bit_index_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      clk_count_q     <= 16'd0;
      bit_index_q     <= 3'd0;
      shift_q         <= 8'h00;
      sync1_q         <= 1'b1;
      rx_sync_q       <= 1'b1;
      stop_ok_q       <= 1'b0;
      stop_bad_q      <= 1'b0;
      data_byte_q     <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      clk_count_q     <= clk_count_d;
      bit_index_q     <= bit_index_d;
      shift_q         <= shift_d;
      sync1_q         <= bus.input_rx;
      rx_sync_q       <= sync1_q;
      stop_ok_q       <= stop_ok_d;
      stop_bad_q      <= stop_bad_d;
      data_valid_q    <= stop_ok_q;
      framing_error_q <= stop_bad_q;
      if (stop_ok_q) data_byte_q <= shift_q;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= par_bad_d;
      parity_error_q  <= stop_ok_q & par_bad_q;
`endif
    end
  end

  assign bus.data_byte     = data_byte_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parity_error_q;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that pairs with the existing `uart_tx` transmitter. It deserialises 8N1 frames (8 data bits, LSB first, one stop bit) from an asynchronous `input_rx` line and presents each byte to the fabric with a one-cycle `data_valid` strobe. It runs on the same system clock as `uart_tx` and uses the same baud-rate derivation, so a `uart_tx` → `uart_rx` loopback works with matching parameters.

## Interface
- `baudrate`, 115200: line bit rate.
- `clk_freq`, 10000000: system clock frequency in Hz.
- `clks_per_bit`, `clk_freq / baudrate` (86 by default): clocks per bit. Integer division. Legal range is 4..65535.
- `half_bit`, `clks_per_bit / 2` (43 by default): start-bit mid-point offset.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `input_rx`, input, 1: asynchronous serial line. Idles high.
- `data_byte`, output, 8: last received byte. Held until the next good frame.
- `data_valid`, output, 1: one-cycle pulse when `data_byte` is updated.
- `framing_error`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_error`, output, 1: one-cycle pulse on a parity mismatch. Tied to 0 unless the macro is defined.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** `input_rx` passes through a 2-FF synchroniser to give `rx_sync`. Both flops reset to 1.
- **Counters:** `clk_count` is 16 bits and `bit_index` is 3 bits. Both clear on every state change.
- **IDLE:**
  - `rx_sync == 0` → START.
- **START:**
  - Count up to `half_bit - 1`.
  - At that count, if `rx_sync == 0` → DATA.
  - Otherwise the start bit was a glitch → IDLE, with no outputs.
- **DATA:**
  - Count up to `clks_per_bit - 1`.
  - At that count, write `rx_sync` into the shift register bit `bit_index` and increment `bit_index`.
  - After bit 7 → PARITY if `UART_RX_PARITY_EN` is defined, otherwise → STOP.
- **PARITY** (macro builds only):
  - Count up to `clks_per_bit - 1`.
  - At that count, latch `par_bad = ^shift ^ rx_sync`, then → STOP.
- **STOP:**
  - Count up to `clks_per_bit - 1`, then sample `rx_sync`.
  - Sampled 1: on the next cycle `data_byte <= shift` and `data_valid = 1`. In macro builds `parity_error = par_bad` in the same cycle. Then → IDLE.
  - Sampled 0: `framing_error = 1` for one cycle, `data_byte` is unchanged, no `data_valid`. Then → BREAK.
- **BREAK:**
  - Wait until `rx_sync == 1`, then → IDLE.
  - This stops a held-low line from being read as repeated frames.
- **Reset values:** state IDLE, counters 0, `data_byte = 0x00`, and `data_valid`, `framing_error`, `parity_error`, `busy` all 0.
- **Reset mid-frame:** asserting `rst` mid-frame abandons the partial byte. No strobe is issued, and `data_byte` returns to 0x00.
- **Error strobes:** `data_valid` and `framing_error` never assert in the same cycle.

## Timing
- **Synchroniser latency:** 2 cycles from the `input_rx` edge to `rx_sync`.
- **Start detect:** IDLE → START on the first edge that sees `rx_sync == 0`.
- **Bit sampling:** bit n (n = 0..7) is sampled `half_bit + (n+1)*clks_per_bit` cycles after START entry. Stop is sampled one bit period after bit 7 (after the parity bit in macro builds).
- **Strobe latency:** `data_valid` is high `half_bit + 9*clks_per_bit + 4` cycles after the `input_rx` falling edge. With defaults that is 821 cycles. Add `clks_per_bit` with parity enabled.
- **Back-to-back frames:** after the STOP sample the receiver is back in IDLE within 2 cycles. A start bit that immediately follows the stop bit, with no idle gap, is therefore accepted.
- **Baud tolerance:** mid-bit sampling gives about ±4% combined clock error.
- **Throughput:** one byte per frame. There is no buffering; the consumer must take `data_byte` before the next `data_valid`.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frames are 8E1. The PARITY state exists, even parity is checked, and `parity_error` pulses together with `data_valid`. The byte is still delivered when parity is bad.
- **Undefined:** frames are 8N1. There is no PARITY state and `parity_error` is constant 0.

## Test plan
- **Good frame:** send 0xA5 at 115200 baud with defaults → exactly one `data_valid` pulse, `data_byte == 0xA5`, `framing_error == 0`, `busy` low after the frame.
- **Start glitch:** drive `input_rx` low for 10 cycles, then high → no strobes, `busy` drops within 45 cycles, `data_byte` unchanged.
- **Framing error:** send 0x3C with the stop bit low, then hold the line low for 3 bit times → one `framing_error` pulse, no `data_valid`, no further strobes until the line returns high. A following 0x55 frame → `data_valid` with `data_byte == 0x55`.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `data_valid` pulses, 10*86 ± 2 cycles apart, carrying 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 4 of 0x81 → no strobe, `data_byte == 0x00`, `busy == 0`. The next 0x7E frame is received correctly.
- **Parity** (`UART_RX_PARITY_EN` defined): send 0x01 with parity bit 1 → `data_valid`, `parity_error == 0`. Send 0x01 with parity bit 0 → `data_valid` and `parity_error` high in the same cycle.
